operand_sequencer: RTL and testbench
====================================

Name: operand_sequencer

Overview:
- Upstream control stage for the calculator arithmetic datapath.
- Accepts operand A, then operand B plus an opcode, over a single valid/ready data bus (keypad/UART entry path).
- Drives the held operands and opcode to the combinational add/sub unit and registers its sum and carry.
- Presents the registered result with a valid/ready handshake to the display/result stage.

Parameters:
- WIDTH, 8, operand and result width in bits (applies to all data ports).

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  synchronous reset, active-high
- data_i  input  WIDTH  operand entry bus
- op_i  input  1  opcode, sampled with operand B: 0 = add, 1 = subtract
- data_valid_i  input  1  data_i/op_i valid
- data_ready_o  output  1  sequencer can accept data_i this cycle
- a_o  output  WIDTH  operand A to arithmetic unit (a_i)
- b_o  output  WIDTH  operand B to arithmetic unit (b_i)
- op_o  output  1  registered opcode to arithmetic unit select
- s_i  input  WIDTH  arithmetic unit result (s_o)
- cout_i  input  1  arithmetic unit carry (cout_o)
- result_o  output  WIDTH  registered result
- carry_o  output  1  registered raw cout_i
- lt_o  output  1  registered flag: op subtract and A < B unsigned; 0 for add
- result_valid_o  output  1  result_o/carry_o/lt_o valid
- result_ready_i  input  1  downstream accepts result
- busy_o  output  1  high in any state other than LOAD_A

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous, active-high on rst_i.
- Reset values:
  - State = LOAD_A.
  - a_o, b_o, op_o, result_o, carry_o, lt_o = 0.
  - result_valid_o = 0, busy_o = 0, data_ready_o = 1 (combinational from state).
- FSM states:
  - LOAD_A: data_ready_o = 1. A transfer occurs when data_valid_i is high in this state; on the transfer, a_o <= data_i and go to LOAD_B. op_i is ignored.
  - LOAD_B: data_ready_o = 1. On a transfer, b_o <= data_i, op_o <= op_i, and go to EXEC.
  - EXEC: exactly one cycle; data_ready_o = 0. Outputs a_o, b_o, op_o have been stable for a full cycle.
    - At the clock edge: result_o <= s_i, carry_o <= cout_i, lt_o <= op_o & (a_o < b_o), and go to RESULT.
  - RESULT: result_valid_o = 1, data_ready_o = 0. Result registers hold unchanged.
    - If result_ready_i is high, go to LOAD_A; result_valid_o drops the next cycle.
- Latency: from the edge accepting B to the first cycle with result_valid_o high is 2 cycles.
- Throughput: one operation per 4 cycles minimum, i.e. with data_valid_i and result_ready_i held high.
- Operand hold: a_o, b_o, op_o hold their values after the result is delivered, until overwritten by the next capture.
- No internal arithmetic on data besides the lt_o comparison; result width stays WIDTH and overflow is reported only via carry_o.
- Boundary conditions:
  - data_valid_i in EXEC/RESULT: ignored, not captured, no error.
  - result_ready_i high outside RESULT: ignored.
  - result_ready_i held low: the sequencer stalls in RESULT indefinitely with the result stable.
  - A == B on subtract: lt_o = 0.
  - rst_i mid-operation (any state): next cycle is reset state and the partial operands are discarded. Reset has priority over every other event.

Optional Feature:
- Macro: OPSEQ_CLEAR_EN.
- Defined:
  - Adds input clear_i (1 bit).
  - clear_i high in any state returns the FSM to LOAD_A at the next edge.
  - Drops result_valid_o; does not clear a_o/b_o/op_o or the result registers.
  - rst_i has priority over clear_i.
- Undefined: no clear_i port; abort only via rst_i.

Test Plan:
- Subtract, no borrow: A=0x2A, B=0x0F, op=1 with a behavioural subtractor model on s_i → result_o=0x1B, lt_o=0, result_valid_o 2 cycles after B accept.
- Subtract, borrow: A=0x05, B=0x09, op=1 → result_o=0xFC, lt_o=1. Add: A=0xF0, B=0x20, op=0 → result_o=0x10, carry_o=1 (model carry), lt_o=0.
- Backpressure: result_ready_i low for 5 cycles with data_valid_i high throughout → data_ready_o=0, result_o stable, no capture. After ready, next A accepted the cycle after return to LOAD_A.
- Back-to-back: data_valid_i and result_ready_i tied high, 10 random pairs → one result every 4 cycles, all match model.
- Reset mid-op: rst_i pulsed in LOAD_B after A=0x77 → all outputs 0, busy_o=0. The next two words are treated as new A and B.
- With OPSEQ_CLEAR_EN: clear_i pulsed in RESULT → result_valid_o=0 next cycle, state LOAD_A. clear_i pulsed together with rst_i → reset values.

Source files
------------

// File: rtl/operand_sequencer.sv
// Operand sequencer: captures A, then B plus opcode, and registers the add/sub unit result.
// Optional OPSEQ_CLEAR_EN adds clear_i, a soft abort back to LOAD_A.
module operand_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef OPSEQ_CLEAR_EN
    input  logic             clear_i,
`endif
    input  logic [WIDTH-1:0] data_i,
    input  logic             op_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             op_o,
    input  logic [WIDTH-1:0] s_i,
    input  logic             cout_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             lt_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic             busy_o
);

    localparam logic [1:0] LOAD_A = 2'd0;
    localparam logic [1:0] LOAD_B = 2'd1;
    localparam logic [1:0] EXEC   = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       abort;

`ifdef OPSEQ_CLEAR_EN
    assign abort = clear_i;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_A:  if (data_valid_i) state_d = LOAD_B;
            LOAD_B:  if (data_valid_i) state_d = EXEC;
            EXEC:    state_d = RESULT;
            RESULT:  if (result_ready_i) state_d = LOAD_A;
            default: state_d = LOAD_A;
        endcase
        if (abort) state_d = LOAD_A;
    end

    // An abort also suppresses any capture scheduled for the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= LOAD_A;
            a_o      <= '0;
            b_o      <= '0;
            op_o     <= 1'b0;
            result_o <= '0;
            carry_o  <= 1'b0;
            lt_o     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!abort) begin
                case (state_q)
                    LOAD_A: begin
                        if (data_valid_i) a_o <= data_i;
                    end
                    LOAD_B: begin
                        if (data_valid_i) begin
                            b_o  <= data_i;
                            op_o <= op_i;
                        end
                    end
                    EXEC: begin
                        result_o <= s_i;
                        carry_o  <= cout_i;
                        lt_o     <= op_o & (a_o < b_o);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_ready_o   = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign busy_o         = (state_q != LOAD_A);
    assign result_valid_o = (state_q == RESULT);

endmodule

// File: tb/tb_operand_sequencer.sv
// Randomised bench for operand_sequencer with a transaction-level reference model and an
// in-bench add/sub unit; OPSEQ_CLEAR_EN additionally exercises clear_i.
module tb_operand_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic [W-1:0] data = '0;
    logic         op = 1'b0;
    logic         dvalid = 1'b0;
    logic         rready = 1'b0;
    logic         dready, op_o, carry_o, lt_o, rvalid, busy, cout;
    logic [W-1:0] a_o, b_o, s, result_o;
    logic [W:0]   sum;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    operand_sequencer #(.WIDTH(W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
`ifdef OPSEQ_CLEAR_EN
        .clear_i        (clr),
`endif
        .data_i         (data),
        .op_i           (op),
        .data_valid_i   (dvalid),
        .data_ready_o   (dready),
        .a_o            (a_o),
        .b_o            (b_o),
        .op_o           (op_o),
        .s_i            (s),
        .cout_i         (cout),
        .result_o       (result_o),
        .carry_o        (carry_o),
        .lt_o           (lt_o),
        .result_valid_o (rvalid),
        .result_ready_i (rready),
        .busy_o         (busy)
    );

    // Arithmetic unit: subtract is a + ~b + 1, so cout means "no borrow".
    assign sum  = op_o ? ({1'b0, a_o} + {1'b0, ~b_o} + 9'd1) : ({1'b0, a_o} + {1'b0, b_o});
    assign s    = sum[W-1:0];
    assign cout = sum[W];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: step counts words taken for the current operation
    // (0 = waiting A, 1 = waiting B, 2 = computing, 3 = result offered).
    bit started = 1'b0;
    int step = 0;
    int m_a = 0, m_b = 0, m_op = 0, m_res = 0, m_carry = 0, m_lt = 0;

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            step = 0;
            m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_carry = 0; m_lt = 0;
        end else if (started) begin
            if (clr) begin
                step = 0;
            end else if (step == 0 && dvalid) begin
                m_a = int'(data);
                step = 1;
            end else if (step == 1 && dvalid) begin
                m_b = int'(data);
                m_op = int'(op);
                step = 2;
            end else if (step == 2) begin
                if (m_op != 0) begin
                    m_res   = (m_a - m_b) & 255;
                    m_carry = (m_a >= m_b) ? 1 : 0;
                    m_lt    = (m_a < m_b) ? 1 : 0;
                end else begin
                    m_res   = (m_a + m_b) & 255;
                    m_carry = (m_a + m_b > 255) ? 1 : 0;
                    m_lt    = 0;
                end
                step = 3;
            end else if (step == 3 && rready) begin
                step = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("data_ready", 32'(dready), (step < 2) ? 1 : 0);
            check("busy", 32'(busy), (step != 0) ? 1 : 0);
            check("result_valid", 32'(rvalid), (step == 3) ? 1 : 0);
            check("a_o", 32'(a_o), m_a);
            check("b_o", 32'(b_o), m_b);
            check("op_o", 32'(op_o), m_op);
            check("result_o", 32'(result_o), m_res);
            check("carry_o", 32'(carry_o), m_carry);
            check("lt_o", 32'(lt_o), m_lt);
        end
    end

    task automatic send(input logic [W-1:0] d, input logic o);
        bit ok = 1'b0;
        dvalid = 1'b1;
        data = d;
        op = o;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = dready;
            @(posedge clk);
            #1;
        end
        dvalid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic o, input logic [W-1:0] er, input logic ec, input logic el);
        send(a, 1'($urandom_range(1)));
        send(b, o);
        check({name, "_exec_not_valid"}, 32'(rvalid), 0);
        @(posedge clk);
        #1;
        check({name, "_valid_lat2"}, 32'(rvalid), 1);
        check({name, "_result"}, 32'(result_o), 32'(er));
        check({name, "_carry"}, 32'(carry_o), 32'(ec));
        check({name, "_lt"}, 32'(lt_o), 32'(el));
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int nres;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", 32'(dready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(rvalid), 0);
        check("rst_a", 32'(a_o), 0);

        run_op("sub_nb", 8'h2A, 8'h0F, 1'b1, 8'h1B, 1'b1, 1'b0);
        run_op("sub_b", 8'h05, 8'h09, 1'b1, 8'hFC, 1'b0, 1'b1);
        run_op("add_c", 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0);
        run_op("sub_eq", 8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0);

        // Backpressure with data_valid held high throughout.
        send(8'h81, 1'b0);
        send(8'h02, 1'b0);
        dvalid = 1'b1;
        data = 8'h55;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("bp_ready", 32'(dready), 0);
        check("bp_result", 32'(result_o), 32'h83);
        check("bp_a_held", 32'(a_o), 32'h81);
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
        check("bp_back_idle", 32'(dready), 1);
        @(posedge clk);
        #1;
        dvalid = 1'b0;
        check("bp_next_a", 32'(a_o), 32'h55);
        pulse_reset();

        // Reset mid-operation; following words start a fresh operation.
        send(8'h77, 1'b0);
        pulse_reset();
        check("midrst_a", 32'(a_o), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ready", 32'(dready), 1);
        run_op("after_rst", 8'h10, 8'h03, 1'b0, 8'h13, 1'b0, 1'b0);

        // Back-to-back: one result every 4 cycles.
        nres = 0;
        dvalid = 1'b1;
        rready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            data = W'($urandom);
            op = 1'($urandom_range(1));
            @(posedge clk);
            #1;
            if (rvalid) nres++;
        end
        dvalid = 1'b0;
        rready = 1'b0;
        check("b2b_count", 32'(nres), 10);
        pulse_reset();

        // Random traffic, including ignored inputs and occasional resets.
        for (int i = 0; i < 400; i++) begin
            dvalid = 1'($urandom_range(1));
            data = W'($urandom);
            op = 1'($urandom_range(1));
            rready = ($urandom_range(3) == 0);
            rst = ($urandom_range(60) == 0);
            @(posedge clk);
            #1;
        end
        dvalid = 1'b0;
        rready = 1'b0;
        rst = 1'b0;
        pulse_reset();

`ifdef OPSEQ_CLEAR_EN
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        @(posedge clk);
        #1;
        check("clr_in_result", 32'(rvalid), 1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_valid", 32'(rvalid), 0);
        check("clr_busy", 32'(busy), 0);
        check("clr_keeps_result", 32'(result_o), 32'h46);
        check("clr_keeps_a", 32'(a_o), 32'h12);
        send(8'h99, 1'b0);
        clr = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        rst = 1'b0;
        check("clr_rst_a", 32'(a_o), 0);
        check("clr_rst_result", 32'(result_o), 0);
        check("clr_rst_busy", 32'(busy), 0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
